// File: rtl/bg_tile_engine_if.sv
// Pixel request / RAM port / result bundle for bg_tile_engine.
interface bg_tile_engine_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 13,
    parameter int BPP    = 2,
    parameter int COL_W  = 5
);
    logic              req;
    logic [X_W-1:0]    req_x;
    logic [Y_W-1:0]    req_y;
    logic              ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              out_valid;
    logic [COL_W-1:0]  out_color;
    logic [BPP-1:0]    out_index;
    logic              out_transp;

    modport master (
        output req, req_x, req_y, ram_data,
        input  ready, ram_addr, out_valid, out_color, out_index, out_transp
    );

    modport slave (
        input  req, req_x, req_y, ram_data,
        output ready, ram_addr, out_valid, out_color, out_index, out_transp
    );
endinterface

// File: rtl/bg_tile_engine.sv
// Background tile renderer: scrolled pixel -> map -> tile pixel -> attribute -> palette colour.
// Optional BG_TILE_FLIP_EN: attribute bit7 h-flip, bit6 v-flip (fetch order MAP->ATTR->PIX->LUT).
module bg_tile_engine #(
    parameter int                X_W       = 10,
    parameter int                Y_W       = 9,
    parameter int                ADDR_W    = 13,
    parameter int                TILE_LOG2 = 4,
    parameter int                MCOL_LOG2 = 6,
    parameter int                MROW_LOG2 = 5,
    parameter int                BPP       = 2,
    parameter int                NPAL_LOG2 = 3,
    parameter int                COL_W     = 5,
    parameter logic [ADDR_W-1:0] MAP_BASE  = 13'h1000,
    parameter logic [ADDR_W-1:0] PIX_BASE  = 13'h0800,
    parameter logic [ADDR_W-1:0] ATTR_BASE = 13'h1800
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             frame_start,
    input  logic [X_W-1:0]                                   scroll_x,
    input  logic [Y_W-1:0]                                   scroll_y,
    input  logic [(2**NPAL_LOG2)*(2**BPP)*COL_W-1:0]         pal_table,
    bg_tile_engine_if.slave                                  bus
);
    localparam int WX_W   = MCOL_LOG2 + TILE_LOG2;
    localparam int WY_W   = MROW_LOG2 + TILE_LOG2;
    localparam int LIN_W  = 8 + 2 * TILE_LOG2;
    localparam int BOFF_W = LIN_W + 3;
    localparam int SEL_W  = 3 - $clog2(BPP);

    typedef enum logic [2:0] {ST_IDLE, ST_MAP, ST_PIX, ST_ATTR, ST_LUT} state_t;
    state_t state_q, state_d;

    logic [X_W-1:0]             sx_sh;
    logic [Y_W-1:0]             sy_sh;
    logic [WX_W-1:0]            wx_q, wx_d;
    logic [WY_W-1:0]            wy_q, wy_d;
    logic [7:0]                 lat_q;
    logic                       accept;
    logic [TILE_LOG2-1:0]       px, py, px_eff, py_eff;
    logic [MCOL_LOG2-1:0]       col;
    logic [MROW_LOG2-1:0]       row;
    logic [7:0]                 tile, pix_byte;
    logic [NPAL_LOG2-1:0]       pal_sel;
    logic [LIN_W-1:0]           lin;
    logic [BOFF_W-1:0]          bitoff;
    logic [SEL_W-1:0]           sel;
    logic [3:0]                 sh;
    logic [BPP-1:0]             idx;
    logic [NPAL_LOG2+BPP-1:0]   pal_k;

    assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_LUT);
    assign accept    = bus.req && bus.ready;

    // World coordinates wrap by truncation to the map size.
    assign wx_d = WX_W'(bus.req_x) + WX_W'(sx_sh);
    assign wy_d = WY_W'(bus.req_y) + WY_W'(sy_sh);

    assign col = wx_q[WX_W-1:TILE_LOG2];
    assign row = wy_q[WY_W-1:TILE_LOG2];
    assign px  = wx_q[TILE_LOG2-1:0];
    assign py  = wy_q[TILE_LOG2-1:0];

`ifdef BG_TILE_FLIP_EN
    // Lat_q holds the tile id here; the attribute arrives during PIX and is kept for LUT.
    logic                 hf_q;
    logic [NPAL_LOG2-1:0] pal_q;
    logic                 hf;
    assign hf       = (state_q == ST_PIX) ? bus.ram_data[7] : hf_q;
    assign px_eff   = hf ? ~px : px;
    assign py_eff   = ((state_q == ST_PIX) && bus.ram_data[6]) ? ~py : py;
    assign tile     = lat_q;
    assign pix_byte = bus.ram_data;
    assign pal_sel  = pal_q;
`else
    assign px_eff   = px;
    assign py_eff   = py;
    assign tile     = bus.ram_data;
    assign pix_byte = lat_q;
    assign pal_sel  = bus.ram_data[NPAL_LOG2-1:0];
`endif

    // Tile size is a power of two, so t*T*T + py*T + px is a plain concatenation.
    assign lin    = {tile, py_eff, px_eff};
    assign bitoff = BOFF_W'(lin) * BOFF_W'(BPP);
    assign sel    = px_eff[SEL_W-1:0];
    assign sh     = 4'(8 - BPP - BPP * int'(sel));
    assign idx    = BPP'(pix_byte >> sh);
    assign pal_k  = {pal_sel, idx};

    always_comb begin
        state_d      = state_q;
        bus.ram_addr = '0;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_MAP;
            ST_MAP: begin
                bus.ram_addr = MAP_BASE + ADDR_W'({row, col});
`ifdef BG_TILE_FLIP_EN
                state_d = ST_ATTR;
`else
                state_d = ST_PIX;
`endif
            end
            ST_PIX: begin
                bus.ram_addr = PIX_BASE + ADDR_W'(bitoff >> 3);
`ifdef BG_TILE_FLIP_EN
                state_d = ST_LUT;
`else
                state_d = ST_ATTR;
`endif
            end
            ST_ATTR: begin
                bus.ram_addr = ATTR_BASE + ADDR_W'({row, col});
`ifdef BG_TILE_FLIP_EN
                state_d = ST_PIX;
`else
                state_d = ST_LUT;
`endif
            end
            ST_LUT:  state_d = accept ? ST_MAP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sx_sh          <= '0;
            sy_sh          <= '0;
            wx_q           <= '0;
            wy_q           <= '0;
            lat_q          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_color  <= '0;
            bus.out_index  <= '0;
            bus.out_transp <= 1'b0;
`ifdef BG_TILE_FLIP_EN
            hf_q           <= 1'b0;
            pal_q          <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                sx_sh <= scroll_x;
                sy_sh <= scroll_y;
            end
            if (accept) begin
                wx_q <= wx_d;
                wy_q <= wy_d;
            end
            if (state_q == ST_ATTR) lat_q <= bus.ram_data;
`ifdef BG_TILE_FLIP_EN
            if (state_q == ST_PIX) begin
                hf_q  <= bus.ram_data[7];
                pal_q <= bus.ram_data[NPAL_LOG2-1:0];
            end
`endif
            bus.out_valid <= (state_q == ST_LUT);
            if (state_q == ST_LUT) begin
                bus.out_index  <= idx;
                bus.out_color  <= pal_table[int'(pal_k)*COL_W +: COL_W];
                bus.out_transp <= (idx == '0);
            end
        end
    end
endmodule

// File: tb/tb_bg_tile_engine.sv
// Directed self-checking bench for bg_tile_engine (default parameters).
module tb_bg_tile_engine;
    localparam int X_W = 10, Y_W = 9, ADDR_W = 13, BPP = 2, NPAL_LOG2 = 3, COL_W = 5;
    localparam int NENT = (2**NPAL_LOG2) * (2**BPP);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    frame_start;
    logic [X_W-1:0]          scroll_x;
    logic [Y_W-1:0]          scroll_y;
    logic [NENT*COL_W-1:0]   pal_table;
    logic [7:0]              mem [0:8191];
    int                      total = 0;
    int                      bad = 0;

    bg_tile_engine_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .BPP(BPP), .COL_W(COL_W)) bus ();

    bg_tile_engine #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .BPP(BPP),
                     .NPAL_LOG2(NPAL_LOG2), .COL_W(COL_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .scroll_x(scroll_x),
        .scroll_y(scroll_y), .pal_table(pal_table), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one isolated pixel from IDLE, capturing the three fetch addresses and the result.
    task automatic do_pixel(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic fs,
                            output logic rdy, output logic [ADDR_W-1:0] a1, a2, a3,
                            output logic v_early, v, output logic [BPP-1:0] ix,
                            output logic [COL_W-1:0] c, output logic tr);
        bus.req = 1'b1; bus.req_x = x; bus.req_y = y; frame_start = fs;
        rdy = bus.ready;
        tick;
        bus.req = 1'b0; frame_start = 1'b0;
        a1 = bus.ram_addr; tick;
        a2 = bus.ram_addr; tick;
        a3 = bus.ram_addr; tick;
        v_early = bus.out_valid; tick;
        v = bus.out_valid; ix = bus.out_index; c = bus.out_color; tr = bus.out_transp;
    endtask

    task automatic test_reset;
        #2;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_color !== 5'd0) begin bad++; $display("FAIL reset_color got=%0d want=0", bus.out_color); end
        total++; if (bus.out_index !== 2'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", bus.out_index); end
        total++; if (bus.out_transp !== 1'b0) begin bad++; $display("FAIL reset_transp got=%0b want=0", bus.out_transp); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.ready); end
        total++; if (bus.ram_addr !== 13'h0) begin bad++; $display("FAIL reset_addr got=%h want=0000", bus.ram_addr); end
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_rst_midfetch;
        int nv;
        bus.req = 1'b1; bus.req_x = 10'd2; bus.req_y = 9'd0;
        tick;
        bus.req = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", bus.ready); end
        total++; if (bus.ram_addr !== 13'h0) begin bad++; $display("FAIL midrst_addr got=%h want=0000", bus.ram_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", bus.out_valid); end
        tick;
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid === 1'b1) nv++;
            tick;
        end
        total++; if (nv != 0) begin bad++; $display("FAIL midrst_strobes got=%0d want=0", nv); end
        total++; if (bus.ram_addr !== 13'h0) begin bad++; $display("FAIL midrst_idle_addr got=%h want=0000", bus.ram_addr); end
    endtask

    task automatic test_basic;
        logic rdy, ve, v, tr;
        logic [ADDR_W-1:0] a1, a2, a3, e2, e3;
        logic [BPP-1:0] ix;
        logic [COL_W-1:0] c;
`ifdef BG_TILE_FLIP_EN
        e2 = 13'h1800; e3 = 13'h08C0;
`else
        e2 = 13'h08C0; e3 = 13'h1800;
`endif
        do_pixel(10'd2, 9'd0, 1'b0, rdy, a1, a2, a3, ve, v, ix, c, tr);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b want=1", rdy); end
        total++; if (a1 !== 13'h1000) begin bad++; $display("FAIL basic_addr1 got=%h want=1000", a1); end
        total++; if (a2 !== e2) begin bad++; $display("FAIL basic_addr2 got=%h want=%h", a2, e2); end
        total++; if (a3 !== e3) begin bad++; $display("FAIL basic_addr3 got=%h want=%h", a3, e3); end
        total++; if (ve !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", ve); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", v); end
        total++; if (ix !== 2'd2) begin bad++; $display("FAIL basic_index got=%0d want=2", ix); end
        total++; if (c !== 5'd9) begin bad++; $display("FAIL basic_color got=%0d want=9", c); end
        total++; if (tr !== 1'b0) begin bad++; $display("FAIL basic_transp got=%0b want=0", tr); end
        tick;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_strobe_len got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [BPP-1:0]   exp_ix [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [COL_W-1:0] exp_c  [8] = '{5'd27, 5'd2, 5'd9, 5'd16, 5'd16, 5'd9, 5'd2, 5'd27};
        int n_acc, ns;
        logic acc, exp_rdy, exp_v;
        n_acc = 0; ns = 0;
        bus.req = 1'b1; bus.req_x = 10'd0; bus.req_y = 9'd0;
        for (int c = 0; c < 37; c++) begin
            exp_rdy = (c > 32) || (c % 4 == 0);
            exp_v   = (c >= 5) && (c <= 33) && ((c - 5) % 4 == 0);
            total++; if (bus.ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b want=%0b", c, bus.ready, exp_rdy); end
            total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid c=%0d got=%0b want=%0b", c, bus.out_valid, exp_v); end
            if (bus.out_valid === 1'b1 && ns < 8) begin
                total++; if (bus.out_index !== exp_ix[ns]) begin bad++; $display("FAIL b2b_index n=%0d got=%0d want=%0d", ns, bus.out_index, exp_ix[ns]); end
                total++; if (bus.out_color !== exp_c[ns]) begin bad++; $display("FAIL b2b_color n=%0d got=%0d want=%0d", ns, bus.out_color, exp_c[ns]); end
                total++; if (bus.out_transp !== (exp_ix[ns] == 2'd0)) begin bad++; $display("FAIL b2b_transp n=%0d got=%0b want=%0b", ns, bus.out_transp, exp_ix[ns] == 2'd0); end
                ns++;
            end else if (bus.out_valid === 1'b1) begin
                ns++;
            end
            acc = bus.req && bus.ready;
            tick;
            if (acc) begin
                n_acc++;
                if (n_acc == 8) bus.req = 1'b0;
                else bus.req_x = 10'(n_acc);
            end
        end
        bus.req = 1'b0;
        total++; if (ns != 8) begin bad++; $display("FAIL b2b_strobes got=%0d want=8", ns); end
    endtask

    task automatic test_scroll_wrap;
        logic rdy, ve, v, tr;
        logic [ADDR_W-1:0] a1, a2, a3, ap;
        logic [BPP-1:0] ix;
        logic [COL_W-1:0] c;
        scroll_x = 10'd1020; scroll_y = 9'd0; frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        do_pixel(10'd10, 9'd0, 1'b0, rdy, a1, a2, a3, ve, v, ix, c, tr);
`ifdef BG_TILE_FLIP_EN
        ap = a3;
`else
        ap = a2;
`endif
        total++; if (a1 !== 13'h1000) begin bad++; $display("FAIL wrap_map_addr got=%h want=1000", a1); end
        total++; if (ap !== 13'h08C1) begin bad++; $display("FAIL wrap_pix_addr got=%h want=08c1", ap); end
        total++; if (ix !== 2'd1) begin bad++; $display("FAIL wrap_index got=%0d want=1", ix); end
        total++; if (c !== 5'd2) begin bad++; $display("FAIL wrap_color got=%0d want=2", c); end
    endtask

    task automatic test_frame_start_same_edge;
        logic rdy, ve, v, tr;
        logic [ADDR_W-1:0] a1, a2, a3;
        logic [BPP-1:0] ix;
        logic [COL_W-1:0] c;
        scroll_x = 10'd0; scroll_y = 9'd0; frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        scroll_y = 9'd16;
        do_pixel(10'd0, 9'd0, 1'b1, rdy, a1, a2, a3, ve, v, ix, c, tr);
        total++; if (a1 !== 13'h1000) begin bad++; $display("FAIL fs_same_edge_map got=%h want=1000", a1); end
        do_pixel(10'd0, 9'd0, 1'b0, rdy, a1, a2, a3, ve, v, ix, c, tr);
        total++; if (a1 !== 13'h1040) begin bad++; $display("FAIL fs_next_map got=%h want=1040", a1); end
        scroll_y = 9'd0; frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

`ifdef BG_TILE_FLIP_EN
    task automatic test_flip;
        logic rdy, ve, v, tr;
        logic [ADDR_W-1:0] a1, a2, a3;
        logic [BPP-1:0] ix;
        logic [COL_W-1:0] c;
        mem[13'h1800] = 8'hC1;
        mem[13'h08FF] = 8'h1B;
        do_pixel(10'd0, 9'd0, 1'b0, rdy, a1, a2, a3, ve, v, ix, c, tr);
        total++; if (a2 !== 13'h1800) begin bad++; $display("FAIL flip_attr_addr got=%h want=1800", a2); end
        total++; if (a3 !== 13'h08FF) begin bad++; $display("FAIL flip_pix_addr got=%h want=08ff", a3); end
        total++; if (ix !== 2'd3) begin bad++; $display("FAIL flip_index got=%0d want=3", ix); end
        total++; if (c !== 5'd20) begin bad++; $display("FAIL flip_color got=%0d want=20", c); end
    endtask
`endif

    initial begin
        rst = 1'b1; frame_start = 1'b0; scroll_x = '0; scroll_y = '0;
        bus.req = 1'b0; bus.req_x = '0; bus.req_y = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int k = 0; k < NENT; k++) pal_table[k*COL_W +: COL_W] = 5'((k * 7 + 3) % 32);
        mem[13'h1000] = 8'h03;
        mem[13'h08C0] = 8'h1B;
        mem[13'h08C1] = 8'hE4;
        mem[13'h1800] = 8'h02;
        test_reset;
        test_rst_midfetch;
        test_basic;
        test_back_to_back;
        test_scroll_wrap;
        test_frame_start_same_edge;
`ifdef BG_TILE_FLIP_EN
        test_flip;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
